// File: rtl/gat_pkg.sv
// Shared widths, sizes and FSM encoding for the GAT attention-score datapath.
package gat_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int NUM_FEATURES = 16;
    localparam int A_DEPTH      = 2 * NUM_FEATURES;
    localparam int NUM_NODES    = 64;
    localparam int ACC_W        = 2 * DATA_WIDTH + $clog2(NUM_FEATURES) + 1;
    localparam int NODE_W       = $clog2(NUM_NODES);
    localparam int K_W          = $clog2(NUM_FEATURES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/attn_mac.sv
// One signed multiply-accumulate lane; sum_o is the value the accumulator takes on a load.
module attn_mac
    import gat_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         load,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] h,
    output logic signed [ACC_W-1:0]      acc_o,
    output logic signed [ACC_W-1:0]      sum_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        prod_ext;

    assign prod     = a * h;
    assign prod_ext = {{(ACC_W - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    assign sum_o    = acc_o + prod_ext;

    // clr wins over load so the closing beat of a row leaves the lane empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_o <= '0;
        end else if (clr) begin
            acc_o <= '0;
        end else if (load) begin
            acc_o <= sum_o;
        end
    end

endmodule

// File: rtl/attn_score_unit.sv
// Per-node src/dst attention dot products over a streamed feature row.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid never drops without a transfer.
module attn_score_unit
    import gat_pkg::*;
#(
    parameter  int N_NODES = NUM_NODES,
    localparam int NIDX_W  = $clog2(N_NODES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            a_rdy_i,
    input  logic [A_DEPTH*DATA_WIDTH-1:0]   a_flat_i,
    input  logic                            h_vld_i,
    input  logic signed [DATA_WIDTH-1:0]    h_data_i,
    input  logic                            h_last_i,
    output logic                            h_rdy_o,
    output logic                            score_vld_o,
    input  logic                            score_rdy_i,
    output logic signed [ACC_W-1:0]         score_src_o,
    output logic signed [ACC_W-1:0]         score_dst_o,
    output logic [NIDX_W-1:0]               node_idx_o,
    output logic                            done_o,
    output logic                            err_o,
    output state_t                          state_dbg_o
);

    state_t                  state_q, state_d;
    logic [K_W-1:0]          k_q;
    logic [NIDX_W-1:0]       node_q;
    logic signed [ACC_W-1:0] score_src_q, score_dst_q;
    logic                    err_q;

    logic                         beat, row_end, accept, last_node;
    logic signed [DATA_WIDTH-1:0] a_src, a_dst;
    logic signed [ACC_W-1:0]      acc_src, acc_dst, sum_src, sum_dst;

    assign beat      = h_vld_i && (state_q == ACCUM);
    assign row_end   = beat && (k_q == K_W'(NUM_FEATURES - 1));
    assign accept    = (state_q == OUT) && score_rdy_i;
    assign last_node = (node_q == NIDX_W'(N_NODES - 1));

    assign a_src = a_flat_i[int'(k_q) * DATA_WIDTH +: DATA_WIDTH];
    assign a_dst = a_flat_i[(NUM_FEATURES + int'(k_q)) * DATA_WIDTH +: DATA_WIDTH];

    attn_mac u_mac_src (
        .clk   (clk),
        .rst   (rst),
        .clr   (row_end),
        .load  (beat),
        .a     (a_src),
        .h     (h_data_i),
        .acc_o (acc_src),
        .sum_o (sum_src)
    );

    attn_mac u_mac_dst (
        .clk   (clk),
        .rst   (rst),
        .clr   (row_end),
        .load  (beat),
        .a     (a_dst),
        .h     (h_data_i),
        .acc_o (acc_dst),
        .sum_o (sum_dst)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (a_rdy_i) state_d = ACCUM;
            ACCUM:   if (row_end) state_d = OUT;
            OUT:     if (accept)  state_d = last_node ? DONE : ACCUM;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        h_rdy_o     = 1'b0;
        score_vld_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            ACCUM:   h_rdy_o     = 1'b1;
            OUT:     score_vld_o = 1'b1;
            DONE:    done_o      = 1'b1;
            default: ;
        endcase
    end

    // Framing follows k alone; h_last_i only feeds the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q         <= '0;
            node_q      <= '0;
            score_src_q <= '0;
            score_dst_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (beat) begin
                k_q <= row_end ? '0 : k_q + 1'b1;
                if (h_last_i != (k_q == K_W'(NUM_FEATURES - 1))) begin
                    err_q <= 1'b1;
                end
            end
            if (row_end) begin
                score_src_q <= sum_src;
                score_dst_q <= sum_dst;
            end
            if (accept) begin
                node_q <= node_q + 1'b1;
            end
        end
    end

    assign score_src_o = score_src_q;
    assign score_dst_o = score_dst_q;
    assign node_idx_o  = node_q;
    assign err_o       = err_q;
    assign state_dbg_o = state_q;

endmodule
